// File: rtl/run_sequencer.sv
// run_sequencer: launches a batch of core runs over the req/ack handshake and times each run.
// Latency: accepted go -> req next cycle; ack in WAIT -> done/next req next cycle.
// Optional RUN_SEQ_MAX_STATS_EN builds the max_cycles tracker; otherwise max_cycles is tied to 0.
module run_sequencer #(
  parameter int CYCLE_BITS     = 16,
  parameter int PROG_BITS      = 3,
  parameter int REQ_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  go,
  input  logic [PROG_BITS-1:0]  prog_count,
  input  logic                  ack,
  output logic                  req,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic [PROG_BITS-1:0]  prog_index,
  output logic [CYCLE_BITS-1:0] last_cycles,
  output logic [CYCLE_BITS-1:0] max_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_SETTLE,
    S_WAIT,
    S_DONE,
    S_FAULT
  } state_t;

  localparam int RC_BITS = (REQ_CYCLES > 1) ? $clog2(REQ_CYCLES) : 1;
  localparam logic [RC_BITS-1:0]    RC_LAST  = RC_BITS'(REQ_CYCLES - 1);
  localparam logic [CYCLE_BITS-1:0] CNT_LAST = CYCLE_BITS'(TIMEOUT_CYCLES - 1);

  state_t                state;
  logic [RC_BITS-1:0]    req_cnt;
  logic [CYCLE_BITS-1:0] run_cnt;
  logic [PROG_BITS-1:0]  total;

  logic go_accept;
  logic ack_exit;
  logic last_run;

  // go is only honoured in the idle-like states; ack only counts while waiting
  assign go_accept = go && ((state == S_IDLE) || (state == S_DONE) || (state == S_FAULT));
  assign ack_exit  = (state == S_WAIT) && ack;
  assign last_run  = (prog_index == (total - PROG_BITS'(1)));

  // Main sequencer: state, counters and all registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      req_cnt     <= '0;
      run_cnt     <= '0;
      total       <= '0;
      req         <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout     <= 1'b0;
      prog_index  <= '0;
      last_cycles <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_FAULT: begin
          if (go) begin
            total       <= prog_count;
            prog_index  <= '0;
            last_cycles <= '0;
            done        <= 1'b0;
            timeout     <= 1'b0;
            req_cnt     <= '0;
            if (prog_count == '0) begin
              // empty batch completes immediately without touching the core
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_REQ;
              req   <= 1'b1;
              busy  <= 1'b1;
            end
          end
        end
        S_REQ: begin
          // ack is stale while the core's PC is being reset, so it is not looked at here
          if (req_cnt == RC_LAST) begin
            state <= S_SETTLE;
            req   <= 1'b0;
          end else begin
            req_cnt <= req_cnt + RC_BITS'(1);
          end
        end
        S_SETTLE: begin
          run_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (ack) begin
            last_cycles <= run_cnt;
            if (last_run) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              prog_index <= prog_index + PROG_BITS'(1);
              req_cnt    <= '0;
              req        <= 1'b1;
              state      <= S_REQ;
            end
          end else if (run_cnt == CNT_LAST) begin
            // counter saturates here, so it can never wrap
            state   <= S_FAULT;
            busy    <= 1'b0;
            timeout <= 1'b1;
          end else begin
            run_cnt <= run_cnt + CYCLE_BITS'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          req   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef RUN_SEQ_MAX_STATS_EN
  logic [CYCLE_BITS-1:0] max_reg;

  // Track the longest completed run since the last accepted go
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      max_reg <= '0;
    end else if (go_accept) begin
      max_reg <= '0;
    end else if (ack_exit && (run_cnt > max_reg)) begin
      max_reg <= run_cnt;
    end
  end

  assign max_cycles = max_reg;
`else
  logic unused_stats;
  assign unused_stats = go_accept ^ ack_exit;
  assign max_cycles   = '0;
`endif

endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer with TIMEOUT_CYCLES reduced to 100.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_run_sequencer;
  localparam int CB = 16;
  localparam int PB = 3;
  localparam int TO = 100;

  logic          clock = 1'b0;
  logic          reset;
  logic          go;
  logic          ack;
  logic [PB-1:0] prog_count;
  logic          req;
  logic          busy;
  logic          done;
  logic          timeout;
  logic [PB-1:0] prog_index;
  logic [CB-1:0] last_cycles;
  logic [CB-1:0] max_cycles;

  int tests = 0;
  int fails = 0;

  run_sequencer #(
    .CYCLE_BITS(CB),
    .PROG_BITS(PB),
    .REQ_CYCLES(2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock),
    .reset(reset),
    .go(go),
    .prog_count(prog_count),
    .ack(ack),
    .req(req),
    .busy(busy),
    .done(done),
    .timeout(timeout),
    .prog_index(prog_index),
    .last_cycles(last_cycles),
    .max_cycles(max_cycles)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] exp_max(input int v);
`ifdef RUN_SEQ_MAX_STATS_EN
    return 32'(v);
`else
    return (v == -1) ? 32'd0 : 32'd0;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // issue a one-cycle go; returns at the falling edge after it was sampled
  task automatic pulse_go(input int pc);
    prog_count = PB'(pc);
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
  endtask

  // wait (bounded) for a req pulse to end; returns number of high samples
  task automatic wait_req_fall(output int hi_cnt);
    bit seen;
    hi_cnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (req) begin
        seen = 1'b1;
        hi_cnt++;
      end else if (seen) begin
        return;
      end
      @(negedge clock);
    end
    check("req_fall_bound", 32'd1, 32'd0);
  endtask

  // called at the falling edge right after req drops: ack is seen at WAIT count n
  task automatic do_ack(input int n);
    ack = 1'b0;
    repeat (n + 1) @(negedge clock);
    ack = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int hi;
    int delays [3];
    delays[0] = 5;
    delays[1] = 20;
    delays[2] = 7;
    go = 1'b0;
    ack = 1'b0;
    prog_count = '0;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("rst_req", 32'(req), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_index", 32'(prog_index), 32'd0);
    check("rst_last", 32'(last_cycles), 32'd0);
    check("rst_max", 32'(max_cycles), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    // single run, ack at WAIT count 9
    pulse_go(1);
    check("t1_busy_req", 32'(busy), 32'd1);
    wait_req_fall(hi);
    check("t1_req_width", 32'(hi), 32'd2);
    check("t1_busy_settle", 32'(busy), 32'd1);
    do_ack(9);
    @(negedge clock);
    ack = 1'b0;
    check("t1_last", 32'(last_cycles), 32'd9);
    check("t1_done", 32'(done), 32'd1);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_max", 32'(max_cycles), exp_max(9));

    // batch of 3 with stale ack held through REQ
    pulse_go(3);
    check("t2_max_clr", 32'(max_cycles), 32'd0);
    check("t2_done_clr", 32'(done), 32'd0);
    for (int k = 0; k < 3; k++) begin
      wait_req_fall(hi);
      check($sformatf("t2_req_width_%0d", k), 32'(hi), 32'd2);
      check($sformatf("t2_index_%0d", k), 32'(prog_index), 32'(k));
      do_ack(delays[k]);
    end
    @(negedge clock);
    ack = 1'b0;
    check("t2_done", 32'(done), 32'd1);
    check("t2_index", 32'(prog_index), 32'd2);
    check("t2_last", 32'(last_cycles), 32'd7);
    check("t2_max", 32'(max_cycles), exp_max(20));
    repeat (3) @(negedge clock);
    check("t2_req_idle", 32'(req), 32'd0);

    // two runs: first acks at 4, second never acks
    pulse_go(2);
    wait_req_fall(hi);
    do_ack(4);
    wait_req_fall(hi);
    ack = 1'b0;
    repeat (100) @(negedge clock);
    check("t3_not_yet", 32'(timeout), 32'd0);
    check("t3_busy_wait", 32'(busy), 32'd1);
    @(negedge clock);
    check("t3_timeout", 32'(timeout), 32'd1);
    check("t3_req", 32'(req), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    check("t3_done", 32'(done), 32'd0);
    check("t3_last", 32'(last_cycles), 32'd4);
    check("t3_index", 32'(prog_index), 32'd1);
    check("t3_max", 32'(max_cycles), exp_max(4));
    repeat (5) @(negedge clock);
    check("t3_hold", 32'(timeout), 32'd1);

    // restart from FAULT
    pulse_go(1);
    check("t3r_timeout_clr", 32'(timeout), 32'd0);
    check("t3r_req", 32'(req), 32'd1);
    check("t3r_last_clr", 32'(last_cycles), 32'd0);
    check("t3r_index_clr", 32'(prog_index), 32'd0);
    wait_req_fall(hi);
    do_ack(3);
    @(negedge clock);
    ack = 1'b0;
    check("t3r_last", 32'(last_cycles), 32'd3);
    check("t3r_done", 32'(done), 32'd1);

    // empty batch from DONE
    pulse_go(0);
    check("t4_done", 32'(done), 32'd1);
    check("t4_req", 32'(req), 32'd0);
    check("t4_busy", 32'(busy), 32'd0);
    check("t4_last_clr", 32'(last_cycles), 32'd0);
    hi = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      if (req) hi++;
    end
    check("t4_no_req", 32'(hi), 32'd0);

    // ack on the last possible WAIT cycle beats the timeout
    pulse_go(1);
    wait_req_fall(hi);
    do_ack(TO - 1);
    @(negedge clock);
    ack = 1'b0;
    check("t6_done", 32'(done), 32'd1);
    check("t6_timeout", 32'(timeout), 32'd0);
    check("t6_last", 32'(last_cycles), 32'(TO - 1));

    // reset in the middle of REQ
    pulse_go(2);
    check("t5_req_on", 32'(req), 32'd1);
    reset = 1'b1;
    #1;
    check("t5a_req", 32'(req), 32'd0);
    check("t5a_busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // go ignored during WAIT, then reset in the middle of WAIT
    pulse_go(3);
    wait_req_fall(hi);
    do_ack(2);
    wait_req_fall(hi);
    ack = 1'b0;
    repeat (5) @(negedge clock);
    prog_count = '0;
    go = 1'b1;
    @(negedge clock);
    go = 1'b0;
    repeat (3) @(negedge clock);
    check("t5_go_busy", 32'(busy), 32'd1);
    check("t5_go_done", 32'(done), 32'd0);
    check("t5_go_index", 32'(prog_index), 32'd1);
    check("t5_go_last", 32'(last_cycles), 32'd2);
    reset = 1'b1;
    #1;
    check("t5b_req", 32'(req), 32'd0);
    check("t5b_busy", 32'(busy), 32'd0);
    check("t5b_index", 32'(prog_index), 32'd0);
    check("t5b_last", 32'(last_cycles), 32'd0);
    check("t5b_max", 32'(max_cycles), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // ack on the first WAIT cycle records 0
    pulse_go(1);
    wait_req_fall(hi);
    check("t7_req_width", 32'(hi), 32'd2);
    do_ack(0);
    @(negedge clock);
    ack = 1'b0;
    check("t7_done", 32'(done), 32'd1);
    check("t7_last", 32'(last_cycles), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
